// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-to-byte-FIFO transfer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ram_fifo_pkg;

   localparam int BYTES_PER_WORD = 4;

   // Controller state encoding, kept as plain constants for legacy tools.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_RD_REQ  = 3'd1;
   localparam state_t ST_RD_WAIT = 3'd2;
   localparam state_t ST_SEND    = 3'd3;
   localparam state_t ST_FINISH  = 3'd4;

   // Index of the final byte within a word.
   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   // Byte of a word in send order: index 0 is the most significant byte.
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ram_to_fifo_ctrl.sv
// Reads word_count 32-bit RAM words from base_addr and streams them MSB-first into a byte FIFO.
// Latency: first fifo_wr 3 cycles after start; 6 cycles per word unstalled; done 1 cycle after last byte.
// Backpressure: fifo_full freezes the byte stream indefinitely; no write is issued while it is high.
module ram_to_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              ram_rd,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [31:0]       ram_rdata,
   input  logic              fifo_full,
   output logic              fifo_wr,
   output logic [7:0]        fifo_wdata,
   output logic              busy,
   output logic              done
);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  remain_q;
   logic [31:0]       word_q;
   logic [1:0]        idx_q;

   // Sequence the transfer: fetch one word, stream its bytes, repeat until the count is exhausted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         word_q   <= '0;
         idx_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (word_count != '0) begin
                     addr_q   <= base_addr;
                     remain_q <= word_count;
                     state    <= ST_RD_REQ;
                  end else begin
                     // Empty request: complete without touching RAM or FIFO.
                     state <= ST_FINISH;
                  end
               end
            end
            ST_RD_REQ: begin
               state <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               // RAM data is valid exactly one cycle after the read strobe.
               word_q <= ram_rdata;
               idx_q  <= '0;
               state  <= ST_SEND;
            end
            ST_SEND: begin
               if (!fifo_full) begin
                  if (idx_q != LAST_IDX) begin
                     idx_q <= idx_q + 2'd1;
                  end else begin
                     remain_q <= remain_q - CNT_W'(1);
                     if (remain_q == CNT_W'(1)) begin
                        state <= ST_FINISH;
                     end else begin
                        // Address wraps naturally at 2^ADDR_W.
                        addr_q <= addr_q + ADDR_W'(1);
                        state  <= ST_RD_REQ;
                     end
                  end
               end
            end
            ST_FINISH: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Decode strobes and status directly from state so reset clears them asynchronously.
   always_comb begin
      ram_rd     = (state == ST_RD_REQ);
      ram_addr   = addr_q;
      fifo_wr    = (state == ST_SEND) && !fifo_full;
      fifo_wdata = word_byte(word_q, idx_q);
      busy       = (state != ST_IDLE);
      done       = (state == ST_FINISH);
   end

endmodule

// File: doc/ram_to_fifo_ctrl.md
RAM_TO_FIFO_CTRL -- requirements
Module: ram_to_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, giving the RAM word-address width.
REQ-002 The block SHALL have parameter CNT_W, default 12, giving the width of the word-count input.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: one-cycle request to begin a transfer.
REQ-006 Port base_addr, input, ADDR_W bits: first RAM word address, sampled with start.
REQ-007 Port word_count, input, CNT_W bits: number of 32-bit words to transfer, sampled with start.
REQ-008 Port ram_rd, output, 1 bit: RAM read strobe.
REQ-009 Port ram_addr, output, ADDR_W bits: RAM word address.
REQ-010 Port ram_rdata, input, 32 bits: RAM read data, valid exactly one cycle after ram_rd.
REQ-011 Port fifo_full, input, 1 bit: the byte FIFO cannot accept a write this cycle.
REQ-012 Port fifo_wr, output, 1 bit: FIFO write strobe.
REQ-013 Port fifo_wdata, output, 8 bits: byte presented to the FIFO.
REQ-014 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 Port done, output, 1 bit: one-cycle pulse at transfer completion.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, SEND and FINISH.
REQ-017 In IDLE with start=1 and word_count!=0, the block SHALL latch base_addr into the address register and word_count into the remaining counter, then go to RD_REQ.
REQ-018 In IDLE with start=1 and word_count=0, the block SHALL go to FINISH and perform no RAM read and no FIFO write.
REQ-019 The block SHALL ignore start in every state other than IDLE.
REQ-020 In RD_REQ the block SHALL drive ram_rd=1 for exactly one cycle with ram_addr equal to the address register, then go to RD_WAIT.
REQ-021 In RD_WAIT the block SHALL capture ram_rdata into a 32-bit word register, clear the byte index to 0, and go to SEND.
REQ-022 In SEND, fifo_wr SHALL equal !fifo_full combinationally, and fifo_wdata SHALL be byte [31:24] at index 0, [23:16] at index 1, [15:8] at index 2 and [7:0] at index 3 (MSB first).
REQ-023 In SEND with fifo_full=1, the state, byte index and word register SHALL hold and no write SHALL occur, with no limit on stall length.
REQ-024 In SEND with fifo_full=0 and index<3, the byte index SHALL increment.
REQ-025 In SEND with fifo_full=0 and index=3, the block SHALL decrement the remaining counter; if the counter was 1 it SHALL go to FINISH, otherwise it SHALL increment the address and go to RD_REQ.
REQ-026 The address register SHALL wrap modulo 2^ADDR_W.
REQ-027 FINISH SHALL assert done=1 for one cycle and return to IDLE.
REQ-028 Unstalled throughput SHALL be 4 bytes per 6 cycles (RD_REQ, RD_WAIT and 4 SEND cycles).
REQ-029 The first fifo_wr SHALL occur 3 cycles after the cycle in which start is sampled, given fifo_full=0.
REQ-030 Outside SEND, fifo_wr SHALL be 0; outside RD_REQ, ram_rd SHALL be 0.

Reset
REQ-031 While reset_n=0, the state SHALL be IDLE, all counters and registers SHALL be 0, and ram_rd, fifo_wr, busy and done SHALL all be 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer immediately, with no further RAM reads or FIFO writes and no done pulse.

Structure
REQ-033 The state enum and the constant BYTES_PER_WORD=4 SHALL reside in the shared package ram_fifo_pkg.
REQ-034 The block SHALL be a single module with no sub-modules, plus a behavioural 32-bit RAM model with 1-cycle read latency used in the bench only.

Verification
REQ-035 Scenario: base_addr=0x010, word_count=1, RAM[0x010]=0xA1B2C3D4, fifo_full=0 -> bytes A1,B2,C3,D4 on consecutive cycles; done pulses the cycle after D4.
REQ-036 Scenario: word_count=3 from 0x7FE with ADDR_W=11 -> reads at 0x7FE, 0x7FF, 0x000; 12 bytes; done once.
REQ-037 Scenario: fifo_full held high for 5 cycles while index=2 -> no writes for 5 cycles; C3 is written the first cycle full drops; no byte is lost or duplicated.
REQ-038 Scenario: word_count=0 -> done the next cycle; ram_rd and fifo_wr never assert.
REQ-039 Scenario: start re-pulsed during SEND -> ignored; byte count unchanged.
REQ-040 Scenario: reset_n dropped after the 2nd byte -> outputs 0 asynchronously; after release, IDLE with no writes until a new start.
